// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexed 3-digit BCD to 7-segment scanner with a
// frame-synchronous input snapshot and optional leading-zero blanking.
module bcd_seg_scan #(
    parameter int unsigned DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hun,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {DIG_U, DIG_T, DIG_H} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    hun_q, tens_q, units_q;
    logic          blank_q, frame_q;
    logic          tick, wrap, blank_h, blank_t, blank;
    logic [3:0]    digit;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    assign tick = presc_q == LAST;
    assign wrap = tick && state_q == DIG_H;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        state_d = state_q;
        if (tick)
            state_d = state_q == DIG_U ? DIG_T : state_q == DIG_T ? DIG_H : DIG_U;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            state_q <= DIG_U;
            hun_q   <= '0;
            tens_q  <= '0;
            units_q <= '0;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            frame_q <= wrap;
            if (wrap) begin
                hun_q   <= hun;
                tens_q  <= tens;
                units_q <= units;
                blank_q <= blank_lz;
            end
        end
    end

    // Invalid digits compare non-zero, so they never trigger blanking.
    assign blank_h = blank_q && hun_q == 4'd0;
    assign blank_t = blank_h && tens_q == 4'd0;

    always_comb begin
        an    = state_q == DIG_H ? 3'b100 : state_q == DIG_T ? 3'b010 : 3'b001;
        digit = state_q == DIG_H ? hun_q : state_q == DIG_T ? tens_q : units_q;
        blank = state_q == DIG_H ? blank_h : state_q == DIG_T ? blank_t : 1'b0;
        seg   = blank ? 7'b0000000 : dec(digit);
    end

    assign frame_done = frame_q;
endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 Parameter DIV, default 50000, SHALL set the number of clk cycles each digit is displayed; legal range 1 to 2^20.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-005 Port hun, input, 4 bits, SHALL be the BCD hundreds digit from the upstream counter.
REQ-006 Port tens, input, 4 bits, SHALL be the BCD tens digit.
REQ-007 Port units, input, 4 bits, SHALL be the BCD units digit.
REQ-008 Port blank_lz, input, 1 bit, SHALL enable leading-zero blanking when 1.
REQ-009 Port seg, output, 7 bits, SHALL carry the segments {a,b,c,d,e,f,g} as bits [6:0], active-high.
REQ-010 Port an, output, 3 bits, SHALL be the one-hot, active-high digit select: an[0] units, an[1] tens, an[2] hundreds.
REQ-011 Port frame_done, output, 1 bit, SHALL pulse once per completed scan frame.

Function
REQ-012 A prescaler SHALL count 0 to DIV-1 and wrap; tick is defined as prescaler==DIV-1.
REQ-013 The scan FSM SHALL have states DIG_U, DIG_T and DIG_H, and on each tick edge SHALL advance U->T->H->U; otherwise it holds.
REQ-014 On the tick edge taking the FSM from DIG_H to DIG_U, hun, tens, units and blank_lz SHALL be captured into snapshot registers; the snapshot is constant at all other times.
REQ-015 an SHALL be 001 in DIG_U, 010 in DIG_T and 100 in DIG_H.
REQ-016 seg SHALL be a function of the FSM state and the snapshot registers only, with no combinational path from any input port.
REQ-017 Decode 0-9 SHALL be: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
REQ-018 Any digit value 10-15 SHALL display as a dash, 0000001.
REQ-019 With snapshot blank_lz=1, the hundreds digit SHALL display seg=0000000 when snapshot hun==0.
REQ-020 With snapshot blank_lz=1, the tens digit SHALL display seg=0000000 when snapshot hun==0 and snapshot tens==0.
REQ-021 The units digit SHALL never be blanked, and an SHALL be asserted for blanked digits.
REQ-022 An invalid digit (value >9) SHALL count as non-zero for blanking purposes.
REQ-023 frame_done SHALL be registered and high for exactly the one clk cycle following the DIG_H->DIG_U edge; it is 0 otherwise.
REQ-024 With DIV=1, the FSM SHALL advance every cycle and frame_done SHALL be high one cycle in every three.
REQ-025 Input-to-display latency SHALL be at most 3*DIV clk cycles after the next frame boundary.
REQ-026 The prescaler SHALL be at least 1 bit wide and SHALL never exceed DIV-1.

Reset
REQ-027 While rst=1, without any clk edge, the block SHALL force: prescaler=0, state=DIG_U, snapshot digits=0, snapshot blank_lz=1, an=001, seg=1111110, frame_done=0.
REQ-028 Asserting rst mid-frame SHALL abandon the frame and produce no frame_done pulse.
REQ-029 After rst deasserts, the first tick SHALL occur DIV clk edges later.

Verification
REQ-030 DIV=4, inputs 1/2/3, blank_lz=1, reset released:
- edge 4: an=010, seg=0000000 (snapshot still zero).
- edge 8: an=100, seg=0000000.
- edge 12: an=001, seg=1111001, frame_done=1 for one cycle.
- edge 16: seg=1101101.
- edge 20: seg=0110000.
REQ-031 Snapshot 0/0/7, blank_lz=1 -> hundreds and tens seg=0000000, units seg=1110000; same digits with blank_lz=0 -> hundreds and tens seg=1111110.
REQ-032 Snapshot 0/5/0, blank_lz=1 -> hundreds seg=0000000, tens seg=1011011, units seg=1111110.
REQ-033 Snapshot 0/A/4, blank_lz=1 -> hundreds seg=0000000, tens seg=0000001, units seg=0110011.
REQ-034 Inputs changed 9/9/9 -> 0/0/0 during DIG_T -> tens and hundreds still show 1111011 until the next DIG_H->DIG_U edge, then units shows 1111110 with the upper digits blanked.
REQ-035 rst pulsed between clk edges during DIG_H -> an=001, seg=1111110, frame_done=0 immediately; the next tick follows DIV edges after release.
